// File: rtl/bmp280_burst_sequencer.sv
// BMP280 burst sequencer: writes N_CFG config words over SPI, then each sample period
// reads N_RD words and streams SYNC + low bytes (+ optional XOR checksum) over UART.
module bmp280_burst_sequencer #(
  parameter int DATA_WIDTH_SPI_CONFIG = 16,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_CFG = 2,
  parameter int N_RD = 9,
  parameter int SAMPLE_PERIOD = 500000,
  parameter logic [DATA_WIDTH_UART-1:0] SYNC_BYTE = 8'hA5,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [N_CFG*DATA_WIDTH_SPI_CONFIG-1:0] cfg_words,
  input  logic [N_RD*DATA_WIDTH_SPI_CONFIG-1:0]  rd_cmds,
  input  logic [DATA_WIDTH_SPI_CONFIG-1:0]       rx_byte_spi,
  input  logic                                   complete_spi,
  input  logic                                   complete_uart,
  output logic                                   enable_spi,
  output logic [DATA_WIDTH_SPI_CONFIG-1:0]       tx_byte_spi,
  output logic                                   enable_uart,
  output logic [DATA_WIDTH_UART-1:0]             tx_byte_uart,
  output logic                                   cfg_done,
  output logic                                   overrun,
  output logic [15:0]                            frame_count
);
  localparam int WS = DATA_WIDTH_SPI_CONFIG;
  localparam int WU = DATA_WIDTH_UART;
  localparam int CI_W = (N_CFG > 1) ? $clog2(N_CFG) : 1;
  localparam int RI_W = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int TI_W = $clog2(N_RD + 2);
  localparam int TM_W = $clog2(SAMPLE_PERIOD);
  localparam int LAST_TX = CHECKSUM_EN ? N_RD + 1 : N_RD;

  typedef enum logic [3:0] {
    IDLE, CFG, CFG_GAP, WAIT, RD, RD_GAP, TX_SYNC, TX_DATA, TX_CSUM, TX_GAP
  } state_t;

  state_t state, next_state;
  logic [CI_W-1:0] cfg_idx;
  logic [RI_W-1:0] rd_idx;
  logic [TI_W-1:0] tx_idx;
  logic [TM_W-1:0] timer;
  logic            timer_run, pending;
  logic [WU-1:0]   rd_buf [N_RD];
  logic [WS-1:0]   cfg_sel, rd_sel;
  logic [WU-1:0]   uart_sel, csum;
  logic            tick, cfg_last, rd_last, tx_last;
  logic            unused_rx;

  assign unused_rx   = ^rx_byte_spi;
  assign tick        = timer_run && (timer == TM_W'(SAMPLE_PERIOD - 1));
  assign cfg_last    = (cfg_idx == CI_W'(N_CFG - 1));
  assign rd_last     = (rd_idx == RI_W'(N_RD - 1));
  assign tx_last     = (tx_idx == TI_W'(LAST_TX));
  assign enable_spi  = (state == CFG) || (state == RD);
  assign enable_uart = (state == TX_SYNC) || (state == TX_DATA) || (state == TX_CSUM);

  // Tx index: 0 = sync, 1..N_RD = buffered bytes, N_RD+1 = checksum.
  always_comb begin
    cfg_sel  = '0;
    rd_sel   = '0;
    csum     = '0;
    uart_sel = SYNC_BYTE;
    for (int k = 0; k < N_CFG; k++)
      if (cfg_idx == CI_W'(k)) cfg_sel = cfg_words[k*WS +: WS];
    for (int k = 0; k < N_RD; k++) begin
      if (rd_idx == RI_W'(k)) rd_sel = rd_cmds[k*WS +: WS];
      if (tx_idx == TI_W'(k + 1)) uart_sel = rd_buf[k];
      csum = csum ^ rd_buf[k];
    end
    if (tx_idx == TI_W'(N_RD + 1)) uart_sel = csum;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CFG;
      CFG:     if (complete_spi) next_state = cfg_last ? RD : CFG_GAP;
      CFG_GAP: next_state = CFG;
      WAIT:    if (tick || pending) next_state = RD;
      RD:      if (complete_spi) next_state = rd_last ? TX_SYNC : RD_GAP;
      RD_GAP:  next_state = RD;
      TX_SYNC, TX_DATA, TX_CSUM:
               if (complete_uart) next_state = tx_last ? WAIT : TX_GAP;
      TX_GAP:  next_state = (tx_idx <= TI_W'(N_RD)) ? TX_DATA : TX_CSUM;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte_spi  <= '0;
      tx_byte_uart <= '0;
      cfg_done     <= 1'b0;
      overrun      <= 1'b0;
      frame_count  <= '0;
      cfg_idx      <= '0;
      rd_idx       <= '0;
      tx_idx       <= '0;
      timer        <= '0;
      timer_run    <= 1'b0;
      pending      <= 1'b0;
      for (int k = 0; k < N_RD; k++) rd_buf[k] <= '0;
    end else begin
      // Output words are loaded on entry so they are stable for the whole handshake.
      if (next_state == CFG)     tx_byte_spi <= cfg_sel;
      else if (next_state == RD) tx_byte_spi <= rd_sel;
      if (next_state == TX_SYNC || next_state == TX_DATA || next_state == TX_CSUM)
        tx_byte_uart <= uart_sel;

      if (state == CFG && complete_spi) begin
        cfg_idx <= cfg_last ? '0 : cfg_idx + 1'b1;
        if (cfg_last) begin
          cfg_done  <= 1'b1;
          timer_run <= 1'b1;
        end
      end

      if (state == CFG && complete_spi && cfg_last) timer <= '0;
      else if (timer_run)                           timer <= tick ? '0 : timer + 1'b1;

      if (state == RD && complete_spi) begin
        for (int k = 0; k < N_RD; k++)
          if (rd_idx == RI_W'(k)) rd_buf[k] <= rx_byte_spi[WU-1:0];
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      end

      // A tick outside WAIT is remembered so the late burst starts as soon as WAIT is reached.
      if (tick && state != WAIT) begin
        overrun <= 1'b1;
        pending <= 1'b1;
      end else if (state == WAIT && next_state == RD) begin
        pending <= 1'b0;
      end

      if (enable_uart && complete_uart) begin
        if (tx_last) begin
          tx_idx      <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          tx_idx <= tx_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bmp280_burst_sequencer.sv
// Bench: two sequencer instances (checksum/200-cycle period, no checksum/50-cycle period)
// driven by SPI/UART responder models; frames compared against a byte-stream reference.
module tb_bmp280_burst_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [31:0] cfg_words;
  logic [47:0] rd_cmds;
  logic [15:0] rx_spi0, rx_spi1, tx_spi0, tx_spi1, fc0, fc1;
  logic        cs0, cs1, cu0, cu1, en_spi0, en_spi1, en_uart0, en_uart1;
  logic [7:0]  tx_uart0, tx_uart1;
  logic        cfg_done0, cfg_done1, overrun0, overrun1;

  bmp280_burst_sequencer #(.N_CFG(2), .N_RD(3), .SAMPLE_PERIOD(200), .CHECKSUM_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_words(cfg_words), .rd_cmds(rd_cmds),
    .rx_byte_spi(rx_spi0), .complete_spi(cs0), .complete_uart(cu0), .enable_spi(en_spi0),
    .tx_byte_spi(tx_spi0), .enable_uart(en_uart0), .tx_byte_uart(tx_uart0),
    .cfg_done(cfg_done0), .overrun(overrun0), .frame_count(fc0));

  bmp280_burst_sequencer #(.N_CFG(2), .N_RD(3), .SAMPLE_PERIOD(50), .CHECKSUM_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_words(cfg_words), .rd_cmds(rd_cmds),
    .rx_byte_spi(rx_spi1), .complete_spi(cs1), .complete_uart(cu1), .enable_spi(en_spi1),
    .tx_byte_spi(tx_spi1), .enable_uart(en_uart1), .tx_byte_uart(tx_uart1),
    .cfg_done(cfg_done1), .overrun(overrun1), .frame_count(fc1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder logs, indexed by instance.
  logic [15:0] stx [2][256];
  logic [7:0]  rxl [2][256];
  logic [7:0]  utx [2][256];
  int          uend [2][256];
  int          bst [2][64];
  int          sn [2], nb [2], un [2], udone [2], gap_err [2], stab_err [2];
  int          scnt [2], ucnt [2], cur_n [2];
  logic        prev_s [2], prev_u [2];
  logic [15:0] s_word [2];
  logic [7:0]  u_word [2];
  logic [7:0]  fixed_rx [3];

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // SPI completes 10 cycles after enable; UART after 1 (inst 0) or 40 (inst 1) cycles.
  initial begin
    logic        en_s, en_u, c_s, c_u;
    logic [15:0] t_s, rx_w;
    logic [7:0]  t_u;
    logic [31:0] rnd;
    int          ulat;
    fixed_rx[0] = 8'h5A; fixed_rx[1] = 8'h3C; fixed_rx[2] = 8'h81;
    for (int g = 0; g < 2; g++) begin
      sn[g] = 0; nb[g] = 0; un[g] = 0; udone[g] = 0; gap_err[g] = 0; stab_err[g] = 0;
      scnt[g] = 0; ucnt[g] = 0; cur_n[g] = 0; prev_s[g] = 0; prev_u[g] = 0;
      s_word[g] = '0; u_word[g] = '0;
    end
    cs0 = 0; cs1 = 0; cu0 = 0; cu1 = 0; rx_spi0 = '0; rx_spi1 = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        en_s = (g == 0) ? en_spi0 : en_spi1;
        t_s  = (g == 0) ? tx_spi0 : tx_spi1;
        en_u = (g == 0) ? en_uart0 : en_uart1;
        t_u  = (g == 0) ? tx_uart0 : tx_uart1;
        ulat = (g == 0) ? 1 : 40;
        c_s = 0; c_u = 0;
        rnd = $urandom;
        rx_w = rnd[15:0];
        if (!rst_n) begin
          scnt[g] = 0; ucnt[g] = 0; prev_s[g] = 0; prev_u[g] = 0;
        end else begin
          if (en_s) begin
            if (scnt[g] == 0) begin
              // CFG hands straight over to the first read, so transaction 2 has no gap.
              if (prev_s[g] && sn[g] != 2) gap_err[g]++;
              cur_n[g] = sn[g];
              s_word[g] = t_s;
              if (sn[g] < 256) stx[g][sn[g]] = t_s;
              if (sn[g] >= 2 && (sn[g] - 2) % 3 == 0 && nb[g] < 64) begin
                bst[g][nb[g]] = cyc;
                nb[g]++;
              end
              sn[g]++;
            end else if (t_s !== s_word[g]) stab_err[g]++;
            scnt[g]++;
            if (scnt[g] == 10) begin
              c_s = 1;
              scnt[g] = 0;
              if (cur_n[g] >= 2 && cur_n[g] < 258) begin
                if (cur_n[g] < 5) rx_w[7:0] = fixed_rx[cur_n[g] - 2];
                rxl[g][cur_n[g] - 2] = rx_w[7:0];
              end
            end
          end
          prev_s[g] = en_s;
          if (en_u) begin
            if (ucnt[g] == 0) begin
              if (prev_u[g]) gap_err[g]++;
              u_word[g] = t_u;
              if (un[g] < 256) utx[g][un[g]] = t_u;
              un[g]++;
            end else if (t_u !== u_word[g]) stab_err[g]++;
            ucnt[g]++;
            if (ucnt[g] == ulat) begin
              c_u = 1;
              ucnt[g] = 0;
              if (udone[g] < 256) uend[g][udone[g]] = cyc;
              udone[g]++;
            end
          end
          prev_u[g] = en_u;
        end
        if (g == 0) begin
          cs0 = c_s; cu0 = c_u;
          if (c_s) rx_spi0 = rx_w;
        end else begin
          cs1 = c_s; cu1 = c_u;
          if (c_s) rx_spi1 = rx_w;
        end
      end
    end
  end

  initial begin
    int          n0, nfr, fl, sn_snap;
    logic [7:0]  x, eb;
    logic [15:0] ew;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_words = {16'h7411, 16'h7590};
    rd_cmds = {16'hFC00, 16'hFB00, 16'hFA00};
    repeat (3) tick();
    chk("rst_enable_spi", en_spi0, 1'b0);
    chk("rst_tx_byte_spi", tx_spi0, 16'h0);
    chk("rst_enable_uart", en_uart0, 1'b0);
    chk("rst_tx_byte_uart", tx_uart0, 8'h0);
    chk("rst_cfg_done", cfg_done0, 1'b0);
    chk("rst_overrun", overrun0, 1'b0);
    chk("rst_frame_count", fc0, 16'h0);
    chk("rst_outputs_inst1", {en_spi1, tx_spi1, en_uart1, tx_uart1, cfg_done1, overrun1, fc1}, '0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_without_start", en_spi0, 1'b0);
    start = 1'b1;
    for (int k = 0; k < 50 && sn[0] < 1; k++) tick();
    start = 1'b0;
    for (int k = 0; k < 100 && sn[0] < 2; k++) tick();
    chk("wait_cfg1", sn[0] >= 2, 1'b1);
    chk("cfg_done_early", cfg_done0, 1'b0);
    chk("cfg_word0", stx[0][0], 16'h7590);
    chk("cfg_word1", stx[0][1], 16'h7411);
    for (int k = 0; k < 100 && sn[0] < 3; k++) tick();
    chk("cfg_done_set", cfg_done0, 1'b1);

    for (int k = 0; k < 1000 && udone[0] < 5; k++) tick();
    chk("wait_frame0", udone[0] >= 5, 1'b1);
    tick();
    chk("frame0_b0", utx[0][0], 8'hA5);
    chk("frame0_b1", utx[0][1], 8'h5A);
    chk("frame0_b2", utx[0][2], 8'h3C);
    chk("frame0_b3", utx[0][3], 8'h81);
    chk("frame0_csum", utx[0][4], 8'hE7);
    chk("frame_count_1", fc0, 16'd1);

    for (int k = 0; k < 2000 && un[1] < 5; k++) tick();
    chk("wait_frame1_inst1", un[1] >= 5, 1'b1);
    chk("nocsum_b0", utx[1][0], 8'hA5);
    chk("nocsum_b3", utx[1][3], 8'h81);
    chk("nocsum_next_sync", utx[1][4], 8'hA5);
    chk("overrun_inst1", overrun1, 1'b1);

    for (int k = 0; k < 4000 && udone[0] < 25; k++) tick();
    chk("wait_5_frames", udone[0] >= 25, 1'b1);

    for (int g = 0; g < 2; g++) begin
      sn_snap = (sn[g] < 256) ? sn[g] : 256;
      for (int i = 0; i < sn_snap; i++) begin
        ew = (i < 2) ? cfg_words[i*16 +: 16] : rd_cmds[((i - 2) % 3)*16 +: 16];
        chk($sformatf("spi_order%0d_%0d", g, i), stx[g][i], ew);
      end
      fl = (g == 0) ? 5 : 4;
      nfr = udone[g] / fl;
      chk($sformatf("frame_count_inst%0d", g), (g == 0) ? fc0 : fc1, 16'(nfr));
      for (int f = 0; f < nfr && (f + 1) * fl <= 256; f++) begin
        x = 8'h00;
        for (int k = 0; k < fl; k++) begin
          if (k == 0) eb = 8'hA5;
          else if (k <= 3) eb = rxl[g][3*f + k - 1];
          else eb = x;
          if (k >= 1 && k <= 3) x = x ^ eb;
          chk($sformatf("uart%0d_f%0d_b%0d", g, f, k), utx[g][f*fl + k], eb);
        end
      end
      chk($sformatf("handshake_gap%0d", g), gap_err[g], 0);
      chk($sformatf("handshake_stable%0d", g), stab_err[g], 0);
    end

    for (int b = 1; b < 5; b++)
      chk($sformatf("period_burst%0d", b), bst[0][b] - bst[0][0], 200 * b);
    chk("no_overrun_inst0", overrun0, 1'b0);
    for (int b = 1; b < nb[1] && 4*b - 1 < udone[1] && 4*b - 1 < 256; b++)
      chk($sformatf("late_burst%0d", b), bst[1][b], uend[1][4*b - 1] + 2);

    for (int k = 0; k < 400 && !(en_spi0 && tx_spi0 == 16'hFB00); k++) tick();
    chk("reach_rd_mid_burst", en_spi0 && tx_spi0 == 16'hFB00, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_enable_spi", en_spi0, 1'b0);
    chk("async_rst_tx_byte_spi", tx_spi0, 16'h0);
    chk("async_rst_rest", {en_uart0, tx_uart0, cfg_done0, overrun0, fc0}, '0);
    n0 = sn[0];
    repeat (2) tick();
    rst_n = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 50 && sn[0] <= n0; k++) tick();
    chk("restart_seen", sn[0] > n0, 1'b1);
    if (n0 < 256) chk("restart_cfg_word0", stx[0][n0], 16'h7590);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
